// File: rtl/mips_isa_pkg.sv
// Instruction-set constants and decoded-instruction types shared by the fetch
// sequencer and its operand decoder.
package mips_isa_pkg;

    localparam logic [5:0]  OP_LOAD  = 6'b001000;
    localparam logic [5:0]  OP_STORE = 6'b001001;
    localparam logic [5:0]  OP_ALU   = 6'b000111;

    localparam logic [31:0] NOP_WORD = 32'h0;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic     src1_v;
        reg_idx_t src1;
        logic     src2_v;
        reg_idx_t src2;
        logic     dst_v;
        reg_idx_t dst;
    } dec_instr_t;

    // One in-flight producer slot.
    typedef struct packed {
        logic     v;
        reg_idx_t r;
    } sb_entry_t;

endpackage

// File: rtl/fetch_hazard_unit_if.sv
// Fetch-side bus: instruction memory address/data plus the decode-facing issue port.
interface fetch_hazard_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  run;
    logic [DATA_WIDTH-1:0] instr_in;
    logic [PC_WIDTH-1:0]   pc_addr;
    logic [DATA_WIDTH-1:0] instr_out;
    logic                  instr_valid;
    logic                  stall;
    logic [CNT_WIDTH-1:0]  bubble_cnt;

    // Fetch unit side.
    modport master (
        input  run,
        input  instr_in,
        output pc_addr,
        output instr_out,
        output instr_valid,
        output stall,
        output bubble_cnt
    );

    // Memory / decode / control side.
    modport slave (
        output run,
        output instr_in,
        input  pc_addr,
        input  instr_out,
        input  instr_valid,
        input  stall,
        input  bubble_cnt
    );
endinterface

// File: rtl/instr_src_dst_decode.sv
// Extracts the source and destination register operands of a candidate word.
module instr_src_dst_decode
    import mips_isa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr_i,
    output dec_instr_t            dec_o
);

    // Low immediate/funct bits carry no register operands.
    logic unused_bits;
    assign unused_bits = ^instr_i[RD_LSB-1:0];

    // Opcode-driven operand decode; unknown opcodes and the NOP word read nothing.
    always_comb begin
        dec_o = '0;
        case (instr_i[OP_MSB:OP_LSB])
            OP_LOAD: begin
                dec_o.src1_v = 1'b1;
                dec_o.src1   = instr_i[RS_MSB:RS_LSB];
                dec_o.dst_v  = 1'b1;
                dec_o.dst    = instr_i[RT_MSB:RT_LSB];
            end
            OP_STORE: begin
                dec_o.src1_v = 1'b1;
                dec_o.src1   = instr_i[RS_MSB:RS_LSB];
                dec_o.src2_v = 1'b1;
                dec_o.src2   = instr_i[RT_MSB:RT_LSB];
            end
            OP_ALU: begin
                dec_o.src1_v = 1'b1;
                dec_o.src1   = instr_i[RS_MSB:RS_LSB];
                dec_o.src2_v = 1'b1;
                dec_o.src2   = instr_i[RT_MSB:RT_LSB];
                dec_o.dst_v  = 1'b1;
                dec_o.dst    = instr_i[RD_MSB:RD_LSB];
            end
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/fetch_hazard_unit.sv
// Fetch sequencer with RAW interlock: drives the PC, replays a held word after
// a stall, and inserts zero bubbles while a source is still in flight.
module fetch_hazard_unit
    import mips_isa_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] PC_BASE    = 'h1030,
    parameter int unsigned         HAZ_DEPTH  = 3,
    parameter int unsigned         CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_hazard_unit_if.master bus
);

    logic [PC_WIDTH-1:0]          pc_q, pc_d;
    logic [DATA_WIDTH-1:0]        instr_q, instr_d;
    logic                         valid_q, valid_d;
    logic [DATA_WIDTH-1:0]        hold_q, hold_d;
    logic                         hold_full_q, hold_full_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    sb_entry_t [HAZ_DEPTH-1:0]    sb_q, sb_d;
    sb_entry_t                    sb_in;

    logic [DATA_WIDTH-1:0]        cand;
    dec_instr_t                   dec;
    logic                         hazard;
    logic                         freeze;

    // The held word takes priority: it was fetched before the PC froze.
    assign cand = hold_full_q ? hold_q : bus.instr_in;

    instr_src_dst_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr_i (cand),
        .dec_o   (dec)
    );

    // Compare candidate sources against every valid in-flight destination.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_q[i].v &&
                ((dec.src1_v && (dec.src1 == sb_q[i].r)) ||
                 (dec.src2_v && (dec.src2 == sb_q[i].r)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign freeze = hazard | ~bus.run;

    // Next-state for PC, issue register, hold register, scoreboard and counter.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = '0;
        valid_d     = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        sb_in       = '0;
        if (!freeze) begin
            instr_d     = cand;
            valid_d     = 1'b1;
            pc_d        = pc_q + PC_WIDTH'(1);
            hold_full_d = 1'b0;
            sb_in.v     = dec.dst_v;
            sb_in.r     = dec.dst_v ? dec.dst : '0;
        end else begin
            if (!hold_full_q) begin
                hold_d      = cand;
                hold_full_d = 1'b1;
            end
            // A hazard seen while run is low is a run freeze, not a hazard bubble.
            if (hazard && bus.run && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
        sb_d[0] = sb_in;
        for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= PC_BASE;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            sb_q        <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            sb_q        <= sb_d;
        end
    end

    assign bus.pc_addr     = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.stall       = freeze;
    assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_hazard_unit.sv
// Directed bench for fetch_hazard_unit with a 1-cycle synchronous memory model.
module tb_fetch_hazard_unit;
    import mips_isa_pkg::*;

    logic clk;
    logic rst;

    fetch_hazard_unit_if #(.DATA_WIDTH(32), .PC_WIDTH(32), .CNT_WIDTH(16)) bus ();

    fetch_hazard_unit #(
        .DATA_WIDTH (32),
        .PC_WIDTH   (32),
        .PC_BASE    (32'h1030),
        .HAZ_DEPTH  (3),
        .CNT_WIDTH  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: registered read, output resets to zero.
    logic [31:0] mem [0:31];
    logic [31:0] rd_off;
    assign rd_off = bus.pc_addr - 32'h1030;
    always @(posedge clk or posedge rst) begin
        if (rst) bus.instr_in <= '0;
        else     bus.instr_in <= mem[rd_off[4:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_load(input int rs, input int rt);
        return {OP_LOAD, 5'(rs), 5'(rt), 16'h0004};
    endfunction
    function automatic logic [31:0] mk_store(input int rs, input int rt);
        return {OP_STORE, 5'(rs), 5'(rt), 16'h0008};
    endfunction
    function automatic logic [31:0] mk_alu(input int rs, input int rt, input int rd, input int fn);
        return {OP_ALU, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    // Leaves the bench at a falling edge, reset released, before the first active edge.
    task automatic reset_dut();
        bus.run = 1'b1;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Main program words (r31 is a base register nobody writes).
    logic [31:0] L0, L1, L2, L3, S4, S5, MUL6, ST6;

    task automatic load_main();
        clear_mem();
        mem[0] = L0; mem[1] = L1; mem[2] = L2; mem[3] = L3;
        mem[4] = S4; mem[5] = S5; mem[6] = MUL6; mem[7] = ST6;
    endtask

    typedef struct {
        logic        run;
        logic [31:0] pc;
        logic        v;
        logic [31:0] instr;
        logic [15:0] cnt;
        logic        stall;
    } vec_t;
    vec_t tbl [19];

    logic [31:0] issued_q [$];
    int          gap_q    [$];

    function automatic logic [31:0] issued_at(input int k);
        return (k < issued_q.size()) ? issued_q[k] : 32'hDEAD_DEAD;
    endfunction
    function automatic int gap_at(input int k);
        return (k < gap_q.size()) ? gap_q[k] : -1;
    endfunction

    // Records each real issue and the number of bubbles that preceded it.
    task automatic trace_run(input int ncyc);
        int gap;
        gap = 0;
        issued_q.delete();
        gap_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (bus.instr_valid && (bus.instr_out != 32'h0)) begin
                issued_q.push_back(bus.instr_out);
                gap_q.push_back(gap);
                gap = 0;
            end else if (!bus.instr_valid) begin
                gap++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        L0   = mk_load(31, 0);
        L1   = mk_load(31, 1);
        L2   = mk_load(31, 2);
        L3   = mk_load(31, 3);
        S4   = mk_alu(1, 0, 4, 6'h22);
        S5   = mk_alu(2, 3, 5, 6'h22);
        MUL6 = mk_alu(4, 5, 6, 6'h18);
        ST6  = mk_store(31, 6);

        //            run  pc          v     instr  cnt  stall
        tbl[0]  = '{1'b1, 32'h1030, 1'b0, 32'h0, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 32'h1031, 1'b1, 32'h0, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 32'h1032, 1'b1, L0,    16'd0, 1'b0};
        tbl[3]  = '{1'b1, 32'h1033, 1'b1, L1,    16'd0, 1'b0};
        tbl[4]  = '{1'b1, 32'h1034, 1'b1, L2,    16'd0, 1'b0};
        tbl[5]  = '{1'b1, 32'h1035, 1'b1, L3,    16'd0, 1'b1};
        tbl[6]  = '{1'b1, 32'h1035, 1'b0, 32'h0, 16'd1, 1'b0};
        tbl[7]  = '{1'b1, 32'h1036, 1'b1, S4,    16'd1, 1'b1};
        tbl[8]  = '{1'b1, 32'h1036, 1'b0, 32'h0, 16'd2, 1'b0};
        tbl[9]  = '{1'b1, 32'h1037, 1'b1, S5,    16'd2, 1'b1};
        tbl[10] = '{1'b1, 32'h1037, 1'b0, 32'h0, 16'd3, 1'b1};
        tbl[11] = '{1'b1, 32'h1037, 1'b0, 32'h0, 16'd4, 1'b1};
        tbl[12] = '{1'b1, 32'h1037, 1'b0, 32'h0, 16'd5, 1'b0};
        tbl[13] = '{1'b1, 32'h1038, 1'b1, MUL6,  16'd5, 1'b1};
        tbl[14] = '{1'b1, 32'h1038, 1'b0, 32'h0, 16'd6, 1'b1};
        tbl[15] = '{1'b1, 32'h1038, 1'b0, 32'h0, 16'd7, 1'b1};
        tbl[16] = '{1'b1, 32'h1038, 1'b0, 32'h0, 16'd8, 1'b0};
        tbl[17] = '{1'b1, 32'h1039, 1'b1, ST6,   16'd8, 1'b0};
        tbl[18] = '{1'b1, 32'h103A, 1'b1, 32'h0, 16'd8, 1'b0};

        // Main program, cycle by cycle.
        load_main();
        reset_dut();
        for (int i = 0; i < 19; i++) begin
            bus.run = tbl[i].run;
            #1;
            check($sformatf("main[%0d].pc", i),    bus.pc_addr,            tbl[i].pc);
            check($sformatf("main[%0d].valid", i), 32'(bus.instr_valid),   32'(tbl[i].v));
            check($sformatf("main[%0d].instr", i), bus.instr_out,          tbl[i].instr);
            check($sformatf("main[%0d].cnt", i),   32'(bus.bubble_cnt),    32'(tbl[i].cnt));
            check($sformatf("main[%0d].stall", i), 32'(bus.stall),         32'(tbl[i].stall));
            @(negedge clk);
        end

        // LOAD r7 -> dependent ALU -> independent ALU.
        clear_mem();
        mem[0] = mk_load(31, 7);
        mem[1] = mk_alu(7, 9, 8, 6'h20);
        mem[2] = mk_alu(1, 2, 10, 6'h20);
        reset_dut();
        trace_run(14);
        check("r7.count",  32'(issued_q.size()), 32'd3);
        check("r7.order0", issued_at(0), mem[0]);
        check("r7.order1", issued_at(1), mem[1]);
        check("r7.order2", issued_at(2), mem[2]);
        check("r7.gap_dep",   32'(gap_at(1)), 32'd3);
        check("r7.gap_indep", 32'(gap_at(2)), 32'd0);
        check("r7.cnt", 32'(bus.bubble_cnt), 32'd3);

        // Register 0 is interlocked like any other register.
        clear_mem();
        mem[0] = mk_load(31, 0);
        mem[1] = mk_alu(0, 31, 1, 6'h20);
        reset_dut();
        trace_run(12);
        check("r0.count", 32'(issued_q.size()), 32'd2);
        check("r0.order1", issued_at(1), mem[1]);
        check("r0.gap", 32'(gap_at(1)), 32'd3);
        check("r0.cnt", 32'(bus.bubble_cnt), 32'd3);

        // run low for 5 cycles while a dependency is pending.
        clear_mem();
        mem[0] = mk_load(31, 1);
        mem[1] = mk_load(31, 2);
        mem[2] = mk_alu(1, 2, 3, 6'h20);
        mem[3] = mk_alu(6, 6, 5, 6'h20);
        reset_dut();
        repeat (3) @(negedge clk);
        bus.run = 1'b0;
        #1;
        check("run.pre.pc",    bus.pc_addr, 32'h1033);
        check("run.pre.instr", bus.instr_out, mem[1]);
        check("run.pre.stall", 32'(bus.stall), 32'd1);
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("run.frz%0d.pc", k),    bus.pc_addr, 32'h1033);
            check($sformatf("run.frz%0d.valid", k), 32'(bus.instr_valid), 32'd0);
            check($sformatf("run.frz%0d.cnt", k),   32'(bus.bubble_cnt), 32'd0);
        end
        @(negedge clk);
        bus.run = 1'b1;
        #1;
        check("run.rel.pc",    bus.pc_addr, 32'h1033);
        check("run.rel.valid", 32'(bus.instr_valid), 32'd0);
        check("run.rel.stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        #1;
        check("run.held.instr", bus.instr_out, mem[2]);
        check("run.held.valid", 32'(bus.instr_valid), 32'd1);
        check("run.held.pc",    bus.pc_addr, 32'h1034);
        @(negedge clk);
        #1;
        check("run.succ.instr", bus.instr_out, mem[3]);
        check("run.succ.valid", 32'(bus.instr_valid), 32'd1);
        check("run.succ.cnt",   32'(bus.bubble_cnt), 32'd0);

        // Reset while a hazard stall has a word in the hold register.
        load_main();
        reset_dut();
        repeat (6) @(negedge clk);
        #1;
        check("rst.pre.pc",    bus.pc_addr, 32'h1035);
        check("rst.pre.valid", 32'(bus.instr_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rst.async.pc",    bus.pc_addr, 32'h1030);
        check("rst.async.instr", bus.instr_out, 32'h0);
        check("rst.async.valid", 32'(bus.instr_valid), 32'd0);
        check("rst.async.cnt",   32'(bus.bubble_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst.post1.instr", bus.instr_out, 32'h0);
        check("rst.post1.valid", 32'(bus.instr_valid), 32'd1);
        check("rst.post1.pc",    bus.pc_addr, 32'h1031);
        @(negedge clk);
        #1;
        check("rst.post2.instr", bus.instr_out, L0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_unit.md
Name: fetch_hazard_unit

Overview:
Fetch sequencer and RAW-hazard interlock that sits in front of the instruction memory. Drives the program counter onto the memory address port and takes the memory's 1-cycle-latency synchronous read data. Checks each fetched instruction against the destinations of the last HAZ_DEPTH issued instructions. On a conflict it holds the PC and issues all-zero bubbles to decode, replacing hand-inserted NOPs in the program image.

Parameters:
DATA_WIDTH, 32, instruction width
PC_WIDTH, 32, program counter width
PC_BASE, 32'h1030, PC value after reset (group program base)
HAZ_DEPTH, 3, in-flight producer window; number of bubbles a back-to-back dependency needs
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = fetch may advance; 0 = freeze and issue bubbles
instr_in  in  DATA_WIDTH  instruction memory data_out (= mem[pc_addr of previous cycle])
pc_addr  out  PC_WIDTH  address to instruction memory ADDR_Prog
instr_out  out  DATA_WIDTH  instruction issued to decode (registered)
instr_valid  out  1  1 = instr_out is a real instruction, 0 = bubble
stall  out  1  combinational: the candidate is held this cycle (hazard or !run)
bubble_cnt  out  CNT_WIDTH  saturating count of hazard bubbles since reset

Behaviour:
- Reset (async, rst=1):
  - pc_addr=PC_BASE; instr_out=0; instr_valid=0; bubble_cnt=0.
  - All scoreboard entries invalid; hold register empty.
- Decode of a candidate (opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11]):
  - LOAD 001000: src rs, dest rt.
  - STORE 001001: src rs and rt, no dest.
  - ALU 000111: src rs and rt, dest rd.
  - All-zero word or any other opcode: no src, no dest.
  - Register 0 is an ordinary register: it is compared and never suppressed.
- Candidate selection: the hold register if it is full, otherwise instr_in.
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {valid, reg[4:0]}.
  - Shifts every cycle.
  - Shift-in value is the issued instruction's dest (valid) or invalid (bubble, or no dest).
- hazard = any candidate src equals any valid scoreboard entry. freeze = hazard | !run.
- Cycle with freeze=0:
  - instr_out <= candidate; instr_valid <= 1.
  - pc_addr <= pc_addr+1, modulo 2^PC_WIDTH.
  - Hold register cleared.
- Cycle with freeze=1:
  - instr_out <= 0; instr_valid <= 0; pc_addr unchanged.
  - Hold register loads the candidate if empty, and keeps its content if full.
  - bubble_cnt increments only if hazard=1 (run-freeze bubbles are not counted); saturates at all-ones.
- Replay correctness: while the PC is frozen at A+1, instr_in settles to mem[A+1]. On release the held word A issues and pc_addr advances to A+2. The next cycle instr_in = mem[A+1] issues. No instruction is lost or duplicated.
- First cycle after reset: instr_in is the memory's reset value 0, which is treated as a valid NOP. It is issued with instr_valid=1 and no dest.
- run=0 for many cycles: the scoreboard drains to all-invalid. A later hazard re-check then passes.
- Latency: a hazard-free instruction appears on instr_out 2 cycles after its address is on pc_addr.
- A dependent instruction issued directly after its producer receives exactly HAZ_DEPTH bubbles.
- rst asserted mid-stall: hold register discarded, state returns to reset values immediately.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode constants OP_LOAD=6'b001000, OP_STORE=6'b001001, OP_ALU=6'b000111;
  - NOP word 32'h0;
  - field bit positions;
  - decoded-instruction struct {src1_v, src1, src2_v, src2, dst_v, dst}.
- One combinational sub-module, instr_src_dst_decode: candidate word -> decoded struct.
- Scoreboard, hold register and PC logic stay in fetch_hazard_unit.

Test Plan:
- Reset release with run=1 and memory zeros -> pc_addr 0x1030, 0x1031, ... incrementing each cycle; instr_valid=1; bubble_cnt=0.
- Program LOAD r0..r3, SUB r4=r1-r0, SUB r5=r2-r3, MUL r6=r4*r5, STORE r6 with no NOPs:
  - exactly 1, 1, 3, 3 bubbles before SUB, SUB, MUL, STORE respectively;
  - bubble_cnt=8;
  - 8 valid issues in the same order with no duplicates;
  - STORE issued in slot 16 counted from the first LOAD.
- LOAD r7 then ALU with rs=r7 -> 3 bubbles. ALU with no dependency on r7 -> 0 bubbles.
- Dependency on register 0 (LOAD r0; ALU rs=r0) -> 3 bubbles, confirming r0 is not suppressed.
- Deassert run for 5 cycles mid-program:
  - pc_addr constant; instr_valid=0 throughout; bubble_cnt unchanged;
  - on reassert, the held instruction issues next, then its successor;
  - a dependency frozen over more than 3 cycles issues with 0 further bubbles.
- Assert rst during a hazard stall -> pc_addr=0x1030, instr_out=0, instr_valid=0 asynchronously; the pre-reset held word never issues.
